// File: rtl/yolo_reduce_core.sv
// Streaming reducer: folds GROUP operands (sum or unsigned max) into one result,
// or passes operands straight through in bypass mode, between two FIFO-style ports.
module yolo_reduce_core #(
  parameter int TBITS = 32,
  parameter int TBYTE = 4,
  parameter int GROUP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [TBITS-1:0] isif_data_dout,
  input  logic [TBYTE-1:0] isif_strb_dout,
  input  logic             isif_last_dout,
  input  logic             isif_user_dout,
  input  logic             isif_empty_n,
  output logic             isif_read,
  output logic [TBITS-1:0] osif_data_din,
  output logic [TBYTE-1:0] osif_strb_din,
  output logic             osif_last_din,
  output logic             osif_user_din,
  input  logic             osif_full_n,
  output logic             osif_write
);

  localparam logic [4:0] GROUP_M1 = 5'(GROUP - 1);

  logic [TBITS-1:0] r_acc;
  logic [4:0]       r_cnt;
  logic [1:0]       r_mode;
  logic             r_out_valid;
  logic [TBITS-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_user;

  logic             w_first;
  logic [1:0]       w_mode;
  logic             w_bypass;
  logic [4:0]       w_g_m1;
  logic [TBITS-1:0] w_max;
  logic [TBITS-1:0] w_comb;
  logic             w_read;
  logic             w_close;
  logic             w_unused;

  assign w_unused = ^{isif_strb_dout, isif_user_dout};

  // The live mode input only matters on the first operand; later ones follow r_mode.
  assign w_first  = (r_cnt == 5'd0);
  assign w_mode   = w_first ? mode : r_mode;
  assign w_bypass = (w_mode == 2'b00);
  assign w_g_m1   = w_bypass ? 5'd0 : GROUP_M1;

  assign w_max  = (isif_data_dout > r_acc) ? isif_data_dout : r_acc;
  assign w_comb = w_first ? isif_data_dout :
                  (w_mode == 2'b10) ? w_max : (r_acc + isif_data_dout);

  // rst gates the pop so nothing is consumed while reset is held.
  assign w_read  = rst & isif_empty_n & (~r_out_valid | osif_full_n);
  assign w_close = w_read & ((r_cnt == w_g_m1) | isif_last_dout);

  assign isif_read     = w_read;
  assign osif_write    = r_out_valid & osif_full_n;
  assign osif_data_din = r_out_data;
  assign osif_last_din = r_out_last;
  assign osif_user_din = r_out_user;
  assign osif_strb_din = {TBYTE{1'b1}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_user  <= 1'b0;
    end else begin
      if (w_read) begin
        r_acc <= w_comb;
        if (w_first) begin
          r_mode <= mode;
        end
        if (w_close) begin
          r_cnt      <= '0;
          r_out_data <= w_comb;
          r_out_last <= isif_last_dout;
          r_out_user <= isif_last_dout & (r_cnt != w_g_m1);
        end else begin
          r_cnt <= r_cnt + 5'd1;
        end
      end
      // A closing group refills the output in the same cycle it drains.
      if (w_close) begin
        r_out_valid <= 1'b1;
      end else if (r_out_valid & osif_full_n) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
